zm_module_scheduler: RTL and testbench
======================================

Name: zm_module_scheduler

Overview:
- Packet-atomic dispatcher and collector for up to 8 HMAC module wrappers that share one ingress bus and one egress bus.
- Ingress: picks a target wrapper per packet with round-robin, filtered by each wrapper's input-FIFO free space, then drives module_in_id/module_in_valid for the whole packet.
- Egress: picks a wrapper holding an output packet, drains all of its data beats, then pops exactly one status byte, then releases the bus.
- Sits between the ingress/egress AXI-stream ports and the wrapper array.

Parameters:
- NUM_MODULES, 4, number of wrappers (1..8); ids 0..NUM_MODULES-1.
- FIFO_DEPTH, 512, wrapper input-FIFO depth in beats.
- MIN_FREE, 8, minimum free input-FIFO beats required to start a packet on a wrapper.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- module_enable  in  NUM_MODULES  per-wrapper enable mask; sampled at packet boundaries only.
- in_valid  in  1  upstream beat valid.
- in_last  in  1  upstream beat last.
- in_ready  out  1  upstream ready.
- module_in_id  out  3  wrapper select, ingress.
- module_in_valid  out  1  broadcast valid to wrappers.
- mod_in_ready  in  NUM_MODULES  per-wrapper in_ready.
- mod_fifo_count  in  10*NUM_MODULES  per-wrapper fifo_in_data_count.
- mod_out_valid  in  NUM_MODULES  per-wrapper out_valid.
- mod_out_last  in  NUM_MODULES  per-wrapper out_last.
- mod_status_valid  in  NUM_MODULES  per-wrapper out_status_valid.
- module_out_id  out  3  wrapper select, egress.
- module_out_ready  out  1  data ready to wrappers.
- out_status_ready  out  1  status ready to wrappers.
- dn_valid  out  1  downstream data valid.
- dn_ready  in  1  downstream data ready.
- dn_status_valid  out  1  downstream status valid.
- dn_status_ready  in  1  downstream status ready.
- in_pkt_count  out  32  packets accepted.
- out_pkt_count  out  32  packets completed (status popped).

Behaviour:
- Reset (synchronous) applies to both FSMs:
  - outputs return to 0; FSMs go to IDLE; counters clear.
  - both round-robin pointers go to NUM_MODULES-1, so module 0 is the first candidate.
  - A reset in mid-packet abandons the packet; wrapper FIFOs are reset by the same reset.
- Ingress FSM, IDLE -> PKT:
  - In IDLE, in_ready=0 and module_in_valid=0.
  - When in_valid=1, candidates are modules with module_enable=1 and (FIFO_DEPTH - mod_fifo_count) >= MIN_FREE, compared at 11-bit width with no wrap.
  - The first candidate after the in-pointer, in circular order, is registered into module_in_id, and the in-pointer is updated to it.
  - Go to PKT. First-beat latency is 1 cycle.
  - No candidate: stay in IDLE and re-evaluate every cycle.
- Ingress FSM, PKT:
  - module_in_valid = in_valid; in_ready = mod_in_ready[module_in_id]. Both are combinational.
  - A handshake with in_last=1 increments in_pkt_count and returns to IDLE.
  - The id stays held for the whole packet, even if enable or count changes.
- Egress FSM, IDLE -> DATA:
  - Candidates are modules with mod_out_valid=1 and module_enable=1.
  - Round-robin select from the out-pointer, registered into module_out_id; go to DATA (1-cycle latency).
- Egress FSM, DATA:
  - dn_valid = mod_out_valid[id]; module_out_ready = dn_ready.
  - A handshake with mod_out_last[id]=1 goes to STATUS.
- Egress FSM, STATUS:
  - dn_status_valid = mod_status_valid[id]; out_status_ready = dn_status_ready.
  - The handshake increments out_pkt_count and returns to IDLE.
  - module_out_ready=0 in this state.
- Outside their states, module_out_ready, out_status_ready, dn_valid and dn_status_valid are 0.
- Ingress and egress are independent and may select the same id concurrently.
- Counters wrap at 2^32.
- Ids >= NUM_MODULES are never issued.
- Simultaneous packet end and new request: IDLE is mandatory for one cycle between packets on each side.

Decomposition:
- Package zm_sched_pkg holds:
  - FSM state enums: in_state_t {IN_IDLE, IN_PKT} and out_state_t {OUT_IDLE, OUT_DATA, OUT_STATUS};
  - the MODULE_ID_W=3 and COUNT_W=10 constants.
- One sub-module, zm_rr_pick: combinational round-robin picker. Inputs are a request vector and a pointer; outputs are a grant id and a found flag. It is instantiated twice.

Test Plan:
1. NUM_MODULES=4, all enabled, counts 0, three 4-beat packets -> module_in_id 0,1,2 in that order; in_pkt_count=3; exactly one IDLE cycle between packets.
2. mod_fifo_count[1]=505 (free 7 < 8), next pick would be 1 -> module 1 is skipped and module 2 is chosen; with all counts at 505, in_ready stays 0 until one count drops to 504.
3. module_enable[0] cleared mid-packet on module 0 -> packet completes on id 0; the next packet goes to id 1.
4. Modules 2 and 3 hold 3-beat packets, with dn_ready toggling 1,0,1 -> module 2 drains fully, its status pops, then module 3; no beat interleaving; out_pkt_count=2.
5. Packet drained from module 1 with mod_status_valid[1]=0 for 5 cycles -> the FSM stays in STATUS and module_out_ready=0; status pops on the 6th cycle, then IDLE.
6. reset asserted during beat 2 of an ingress packet -> next cycle in_ready=0, module_in_id=0, counters 0; the next packet selects module 0.

Source files
------------

// File: rtl/zm_sched_pkg.sv
// ============================================================================
//  Module   : zm_sched_pkg
//  Brief    : Shared state encodings and widths for the HMAC module scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zm_sched_pkg;

    localparam int MODULE_ID_W = 3;
    localparam int COUNT_W     = 10;

    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_PKT  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE   = 2'd0,
        OUT_DATA   = 2'd1,
        OUT_STATUS = 2'd2
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/zm_module_scheduler_if.sv
// ============================================================================
//  Module   : zm_module_scheduler_if
//  Brief    : Ingress/egress handshake bundle between scheduler and wrappers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zm_module_scheduler_if #(
    parameter int NUM_MODULES = 4
) ();
    import zm_sched_pkg::*;

    logic [NUM_MODULES-1:0]         module_enable;
    logic                           in_valid;
    logic                           in_last;
    logic                           in_ready;
    logic [MODULE_ID_W-1:0]         module_in_id;
    logic                           module_in_valid;
    logic [NUM_MODULES-1:0]         mod_in_ready;
    logic [COUNT_W*NUM_MODULES-1:0] mod_fifo_count;
    logic [NUM_MODULES-1:0]         mod_out_valid;
    logic [NUM_MODULES-1:0]         mod_out_last;
    logic [NUM_MODULES-1:0]         mod_status_valid;
    logic [MODULE_ID_W-1:0]         module_out_id;
    logic                           module_out_ready;
    logic                           out_status_ready;
    logic                           dn_valid;
    logic                           dn_ready;
    logic                           dn_status_valid;
    logic                           dn_status_ready;
    logic [31:0]                    in_pkt_count;
    logic [31:0]                    out_pkt_count;

    modport master (
        input  module_enable, in_valid, in_last, mod_in_ready, mod_fifo_count,
               mod_out_valid, mod_out_last, mod_status_valid, dn_ready, dn_status_ready,
        output in_ready, module_in_id, module_in_valid, module_out_id, module_out_ready,
               out_status_ready, dn_valid, dn_status_valid, in_pkt_count, out_pkt_count
    );

    modport slave (
        output module_enable, in_valid, in_last, mod_in_ready, mod_fifo_count,
               mod_out_valid, mod_out_last, mod_status_valid, dn_ready, dn_status_ready,
        input  in_ready, module_in_id, module_in_valid, module_out_id, module_out_ready,
               out_status_ready, dn_valid, dn_status_valid, in_pkt_count, out_pkt_count
    );

endinterface

`default_nettype wire

// File: rtl/zm_rr_pick.sv
// ============================================================================
//  Module   : zm_rr_pick
//  Brief    : Combinational round-robin picker; first request after ptr_i.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zm_rr_pick
    import zm_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req_i,
    input  logic [MODULE_ID_W-1:0] ptr_i,
    output logic [MODULE_ID_W-1:0] grant_o,
    output logic                   found_o
);

    logic [7:0]             req_wide;
    logic [MODULE_ID_W-1:0] cand;

    assign req_wide = 8'(req_i);

    // Circular increment modulo N; ptr and k are both <= N so one subtract suffices.
    function automatic logic [MODULE_ID_W-1:0] wrap_add(input logic [MODULE_ID_W-1:0] p,
                                                        input int k);
        logic [3:0] s;
        s = {1'b0, p} + 4'(k);
        if (s >= 4'(N)) begin
            s = s - 4'(N);
        end
        return s[MODULE_ID_W-1:0];
    endfunction

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = wrap_add(ptr_i, k);
            if (!found_o && req_wide[cand]) begin
                found_o = 1'b1;
                grant_o = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/zm_module_scheduler.sv
// ============================================================================
//  Module   : zm_module_scheduler
//  Brief    : Packet-atomic ingress dispatcher and egress collector for wrappers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zm_module_scheduler
    import zm_sched_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int FIFO_DEPTH  = 512,
    parameter int MIN_FREE    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    zm_module_scheduler_if.master bus
);

    localparam logic [MODULE_ID_W-1:0] c_PTR_RST = MODULE_ID_W'(NUM_MODULES - 1);

    logic [NUM_MODULES-1:0] in_req;
    logic [NUM_MODULES-1:0] out_req;
    logic [MODULE_ID_W-1:0] in_grant;
    logic [MODULE_ID_W-1:0] out_grant;
    logic                   in_found;
    logic                   out_found;
    logic [7:0]             in_rdy_w;
    logic [7:0]             out_vld_w;
    logic [7:0]             out_last_w;
    logic [7:0]             st_vld_w;

    in_state_t              in_state_q, in_state_d;
    logic [MODULE_ID_W-1:0] in_id_q, in_id_d;
    logic [MODULE_ID_W-1:0] in_ptr_q, in_ptr_d;
    logic [31:0]            in_cnt_q, in_cnt_d;

    out_state_t             out_state_q, out_state_d;
    logic [MODULE_ID_W-1:0] out_id_q, out_id_d;
    logic [MODULE_ID_W-1:0] out_ptr_q, out_ptr_d;
    logic [31:0]            out_cnt_q, out_cnt_d;

    // Free space compared as count + MIN_FREE <= DEPTH so an over-range count never wraps.
    for (genvar g = 0; g < NUM_MODULES; g++) begin : g_cand
        assign in_req[g] = bus.module_enable[g] &&
            (({1'b0, bus.mod_fifo_count[g*COUNT_W +: COUNT_W]} + 11'(MIN_FREE)) <= 11'(FIFO_DEPTH));
    end

    assign out_req    = bus.mod_out_valid & bus.module_enable;
    assign in_rdy_w   = 8'(bus.mod_in_ready);
    assign out_vld_w  = 8'(bus.mod_out_valid);
    assign out_last_w = 8'(bus.mod_out_last);
    assign st_vld_w   = 8'(bus.mod_status_valid);

    zm_rr_pick #(.N(NUM_MODULES)) u_in_pick (
        .req_i   (in_req),
        .ptr_i   (in_ptr_q),
        .grant_o (in_grant),
        .found_o (in_found)
    );

    zm_rr_pick #(.N(NUM_MODULES)) u_out_pick (
        .req_i   (out_req),
        .ptr_i   (out_ptr_q),
        .grant_o (out_grant),
        .found_o (out_found)
    );

    always_comb begin
        in_state_d          = in_state_q;
        in_id_d             = in_id_q;
        in_ptr_d            = in_ptr_q;
        in_cnt_d            = in_cnt_q;
        bus.in_ready        = 1'b0;
        bus.module_in_valid = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (bus.in_valid && in_found) begin
                    in_id_d    = in_grant;
                    in_ptr_d   = in_grant;
                    in_state_d = IN_PKT;
                end
            end
            IN_PKT: begin
                bus.module_in_valid = bus.in_valid;
                bus.in_ready        = in_rdy_w[in_id_q];
                if (bus.in_valid && in_rdy_w[in_id_q] && bus.in_last) begin
                    in_cnt_d   = in_cnt_q + 32'd1;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    always_comb begin
        out_state_d          = out_state_q;
        out_id_d             = out_id_q;
        out_ptr_d            = out_ptr_q;
        out_cnt_d            = out_cnt_q;
        bus.dn_valid         = 1'b0;
        bus.module_out_ready = 1'b0;
        bus.dn_status_valid  = 1'b0;
        bus.out_status_ready = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (out_found) begin
                    out_id_d    = out_grant;
                    out_ptr_d   = out_grant;
                    out_state_d = OUT_DATA;
                end
            end
            OUT_DATA: begin
                bus.dn_valid         = out_vld_w[out_id_q];
                bus.module_out_ready = bus.dn_ready;
                if (out_vld_w[out_id_q] && bus.dn_ready && out_last_w[out_id_q]) begin
                    out_state_d = OUT_STATUS;
                end
            end
            OUT_STATUS: begin
                bus.dn_status_valid  = st_vld_w[out_id_q];
                bus.out_status_ready = bus.dn_status_ready;
                if (st_vld_w[out_id_q] && bus.dn_status_ready) begin
                    out_cnt_d   = out_cnt_q + 32'd1;
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_q  <= IN_IDLE;
            in_id_q     <= '0;
            in_ptr_q    <= c_PTR_RST;
            in_cnt_q    <= '0;
            out_state_q <= OUT_IDLE;
            out_id_q    <= '0;
            out_ptr_q   <= c_PTR_RST;
            out_cnt_q   <= '0;
        end else begin
            in_state_q  <= in_state_d;
            in_id_q     <= in_id_d;
            in_ptr_q    <= in_ptr_d;
            in_cnt_q    <= in_cnt_d;
            out_state_q <= out_state_d;
            out_id_q    <= out_id_d;
            out_ptr_q   <= out_ptr_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign bus.module_in_id  = in_id_q;
    assign bus.module_out_id = out_id_q;
    assign bus.in_pkt_count  = in_cnt_q;
    assign bus.out_pkt_count = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_zm_module_scheduler.sv
// ============================================================================
//  Module   : tb_zm_module_scheduler
//  Brief    : Randomized scoreboard bench for the HMAC module scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zm_module_scheduler;
    import zm_sched_pkg::*;

    localparam int NM = 4;
    localparam int FD = 512;
    localparam int MF = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    zm_module_scheduler_if #(.NUM_MODULES(NM)) bus ();

    zm_module_scheduler #(.NUM_MODULES(NM), .FIFO_DEPTH(FD), .MIN_FREE(MF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Wrapper input-FIFO fill levels seen by the scheduler.
    int fifo_cnt [NM];
    always_comb begin
        bus.mod_fifo_count = '0;
        for (int m = 0; m < NM; m++) begin
            bus.mod_fifo_count[m*COUNT_W +: COUNT_W] = 10'(fifo_cnt[m]);
        end
    end

    // Reference model state
    int in_ptr_m;
    int out_ptr_m;
    int exp_in_q [$];
    typedef struct { int id; int len; } opkt_t;
    opkt_t exp_out_q [$];

    // Egress wrapper model: per-module packet lists with status delays
    int q_len [NM][16];
    int q_sd  [NM][16];
    int q_num [NM];
    int q_head[NM];
    int beat  [NM];
    bit ddone [NM];
    int sd_cnt[NM];
    bit srdy_force = 1'b0;

    function automatic int model_pick();
        for (int k = 1; k <= NM; k++) begin
            int m;
            m = (in_ptr_m + k) % NM;
            if (bus.module_enable[m] && (FD - fifo_cnt[m]) >= MF) return m;
        end
        return -1;
    endfunction

    always begin
        @(negedge clk);
        for (int m = 0; m < NM; m++) begin
            bus.mod_in_ready[m] = ($urandom_range(0, 3) != 0);
            bus.mod_out_valid[m]    = 1'b0;
            bus.mod_out_last[m]     = 1'b0;
            bus.mod_status_valid[m] = 1'b0;
            if (q_head[m] < q_num[m]) begin
                if (!ddone[m]) begin
                    bus.mod_out_valid[m] = (beat[m] == 0) || ($urandom_range(0, 3) != 0);
                    bus.mod_out_last[m]  = (beat[m] == q_len[m][q_head[m]] - 1);
                end else begin
                    bus.mod_status_valid[m] = (sd_cnt[m] == 0);
                    if (sd_cnt[m] > 0) sd_cnt[m]--;
                end
            end
        end
        bus.dn_ready        = 1'($urandom_range(0, 1));
        bus.dn_status_ready = srdy_force ? 1'b1 : ($urandom_range(0, 2) != 0);
        #2;
        if (!reset) begin
            int id;
            id = int'(bus.module_out_id);
            if (id < NM) begin
                if (bus.module_out_ready && bus.mod_out_valid[id]) begin
                    beat[id]++;
                    if (bus.mod_out_last[id]) begin
                        ddone[id]  = 1'b1;
                        sd_cnt[id] = q_sd[id][q_head[id]];
                    end
                end
                if (bus.out_status_ready && bus.mod_status_valid[id]) begin
                    q_head[id]++;
                    beat[id]  = 0;
                    ddone[id] = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    bit in_first = 1'b1, gap_pend = 1'b0;
    int exp_in_cnt = 0;
    bit e_first = 1'b1, e_stat = 1'b0;
    int exp_out_cnt = 0, cur_id = 0, cur_len = 0, beats_seen = 0;

    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            in_first = 1'b1; gap_pend = 1'b0; exp_in_cnt = 0; exp_in_q.delete();
            e_first = 1'b1; e_stat = 1'b0; exp_out_cnt = 0; exp_out_q.delete();
        end else begin
            if (gap_pend) begin
                chk("in_idle_gap", {bus.module_in_valid, bus.in_ready}, 0);
                gap_pend = 1'b0;
            end
            if (bus.module_in_valid && bus.in_ready) begin
                if (in_first) begin
                    if (exp_in_q.size() == 0) chk("in_unexpected_pkt", 1, 0);
                    else chk("module_in_id", bus.module_in_id, exp_in_q.pop_front());
                    chk("in_pkt_count", bus.in_pkt_count, exp_in_cnt);
                    in_first = 1'b0;
                end
                if (bus.in_last) begin
                    in_first = 1'b1;
                    gap_pend = 1'b1;
                    exp_in_cnt++;
                end
            end
            if (e_stat) chk("status_no_data", {bus.module_out_ready, bus.dn_valid}, 0);
            if (bus.dn_valid && bus.module_out_ready) begin
                if (e_first) begin
                    if (exp_out_q.size() == 0) begin
                        chk("eg_unexpected_pkt", 1, 0);
                        cur_id = int'(bus.module_out_id); cur_len = 0;
                    end else begin
                        opkt_t p;
                        p = exp_out_q.pop_front();
                        cur_id = p.id; cur_len = p.len;
                        chk("module_out_id", bus.module_out_id, cur_id);
                    end
                    beats_seen = 0;
                    e_first = 1'b0;
                end else begin
                    chk("eg_no_interleave", bus.module_out_id, cur_id);
                end
                beats_seen++;
                if (bus.mod_out_last[bus.module_out_id]) e_stat = 1'b1;
            end
            if (bus.dn_status_valid && bus.out_status_ready) begin
                chk("eg_beats", beats_seen, cur_len);
                chk("eg_status_id", bus.module_out_id, cur_id);
                chk("out_pkt_count", bus.out_pkt_count, exp_out_cnt);
                exp_out_cnt++;
                e_stat  = 1'b0;
                e_first = 1'b1;
            end
        end
    end

    task automatic send_pkt(input int len);
        int  nb     = 0;
        bit  picked = 1'b0;
        int  guard  = 0;
        int  e;
        while (nb < len && guard < 2000) begin
            @(negedge clk);
            guard++;
            bus.in_valid = picked ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_last  = (nb == len - 1);
            #1;
            if (!picked) begin
                e = model_pick();
                if (e >= 0) begin
                    exp_in_q.push_back(e);
                    in_ptr_m = e;
                    picked   = 1'b1;
                end
            end else if (bus.in_valid && bus.in_ready) begin
                nb++;
            end
        end
        if (nb < len) chk("in_pkt_timeout", nb, len);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic eg_begin();
        for (int m = 0; m < NM; m++) begin
            q_num[m] = 0; q_head[m] = 0; beat[m] = 0; ddone[m] = 1'b0; sd_cnt[m] = 0;
        end
    endtask

    task automatic eg_load(input int m, input int len, input int sd);
        q_len[m][q_num[m]] = len;
        q_sd[m][q_num[m]]  = sd;
        q_num[m]++;
    endtask

    // Expected drain order: round robin over modules still holding packets.
    task automatic eg_order();
        int h[NM];
        bit any;
        for (int m = 0; m < NM; m++) h[m] = 0;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 1; k <= NM && !any; k++) begin
                int m;
                m = (out_ptr_m + k) % NM;
                if (h[m] < q_num[m]) begin
                    opkt_t p;
                    p.id = m; p.len = q_len[m][h[m]];
                    exp_out_q.push_back(p);
                    h[m]++;
                    out_ptr_m = m;
                    any = 1'b1;
                end
            end
        end
    endtask

    task automatic eg_wait();
        int  t = 0;
        bit  done = 1'b0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
            done = (exp_out_q.size() == 0) && e_first;
            for (int m = 0; m < NM; m++) if (q_head[m] != q_num[m]) done = 1'b0;
        end
        chk("eg_drain_done", done, 1);
    endtask

    task automatic rand_counts(input bit rand_en);
        int vals[8] = '{0, 100, 503, 504, 505, 511, 512, 700};
        int r;
        for (int m = 0; m < NM; m++) fifo_cnt[m] = vals[$urandom_range(0, 7)];
        if (rand_en) bus.module_enable = 4'($urandom_range(0, 15));
        r = $urandom_range(0, NM - 1);
        bus.module_enable[r] = 1'b1;
        fifo_cnt[r] = $urandom_range(0, 504);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.module_enable = 4'hF;
        for (int m = 0; m < NM; m++) fifo_cnt[m] = 0;
        eg_begin();
        in_ptr_m = NM - 1; out_ptr_m = NM - 1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_module_in_valid", bus.module_in_valid, 0);
        chk("rst_dn_valid", {bus.dn_valid, bus.dn_status_valid, bus.module_out_ready}, 0);
        chk("rst_ids", {bus.module_in_id, bus.module_out_id}, 0);
        chk("rst_counts", bus.in_pkt_count + bus.out_pkt_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Three 4-beat packets on an empty, fully enabled array
        repeat (3) send_pkt(4);
        chk("in_pkt_count_after3", bus.in_pkt_count, 3);
        send_pkt(4);

        // Module 1 short on space is skipped
        fifo_cnt[1] = 505;
        send_pkt(4);
        send_pkt(4);

        // Nothing has room: ingress stays stalled until one FIFO drains a beat
        for (int m = 0; m < NM; m++) fifo_cnt[m] = 505;
        fork
            send_pkt(2);
            begin
                repeat (6) begin
                    @(negedge clk);
                    #2;
                    chk("starved_in_ready", {bus.in_ready, bus.module_in_valid}, 0);
                end
                @(negedge clk);
                fifo_cnt[3] = 504;
            end
        join
        for (int m = 0; m < NM; m++) fifo_cnt[m] = 0;

        // Disabling the active module mid-packet does not move the packet
        fork
            send_pkt(6);
            begin
                repeat (3) @(negedge clk);
                bus.module_enable = 4'b1110;
            end
        join
        send_pkt(4);
        bus.module_enable = 4'hF;

        for (int i = 0; i < 15; i++) begin
            rand_counts(1'b1);
            send_pkt($urandom_range(1, 6));
        end
        bus.module_enable = 4'hF;
        for (int m = 0; m < NM; m++) fifo_cnt[m] = 0;

        // Two 3-beat packets queued on modules 2 and 3
        @(negedge clk); #1;
        eg_begin();
        eg_load(2, 3, 1);
        eg_load(3, 3, 1);
        eg_order();
        eg_wait();
        chk("out_pkt_count_two", bus.out_pkt_count, 2);

        // Late status from module 1
        @(negedge clk); #1;
        srdy_force = 1'b1;
        eg_begin();
        eg_load(1, 3, 5);
        eg_order();
        eg_wait();
        srdy_force = 1'b0;

        for (int r = 0; r < 3; r++) begin
            @(negedge clk); #1;
            eg_begin();
            for (int m = 0; m < NM; m++) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) eg_load(m, $urandom_range(1, 5), $urandom_range(0, 3));
            end
            eg_order();
            fork
                eg_wait();
                for (int i = 0; i < 5; i++) begin
                    rand_counts(1'b0);
                    send_pkt($urandom_range(1, 5));
                end
            join
        end
        for (int m = 0; m < NM; m++) fifo_cnt[m] = 0;

        // Reset in the middle of an ingress packet
        begin
            int nb = 0, guard = 0, e;
            bit picked = 1'b0;
            while (nb < 1 && guard < 500) begin
                @(negedge clk);
                guard++;
                bus.in_valid = 1'b1;
                bus.in_last  = 1'b0;
                #1;
                if (!picked) begin
                    e = model_pick();
                    if (e >= 0) begin exp_in_q.push_back(e); in_ptr_m = e; picked = 1'b1; end
                end else if (bus.in_ready) begin
                    nb++;
                end
            end
            chk("pre_reset_beat", nb, 1);
            @(negedge clk);
            reset = 1'b1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            in_ptr_m = NM - 1; out_ptr_m = NM - 1;
            #1;
            chk("post_rst_in_ready", bus.in_ready, 0);
            chk("post_rst_in_id", bus.module_in_id, 0);
            chk("post_rst_counts", bus.in_pkt_count + bus.out_pkt_count, 0);
        end
        send_pkt(3);
        repeat (3) @(negedge clk);
        #1;
        chk("final_in_pkt_count", bus.in_pkt_count, exp_in_cnt);
        chk("final_in_pkt_one", bus.in_pkt_count, 1);
        chk("final_out_pkt_count", bus.out_pkt_count, exp_out_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
